// File: rtl/iic_cfg_seq_if.sv
// I2C pin bundle plus register-table lookup for the config sequencer.
//   tbl_idx          : sequencer -> table, current entry index
//   tbl_reg/tbl_data : table -> sequencer, {register, value} for tbl_idx
//   sda_i/scl_i      : pad inputs (wired-AND bus level)
//   sda_oe/scl_oe    : 1 = pull line low, 0 = release
// master modport is the sequencer side; slave modport is the pads/table side.
interface iic_cfg_seq_if #(
  parameter int unsigned IDX_W = 1
);
  logic [IDX_W-1:0] tbl_idx;
  logic [7:0]       tbl_reg;
  logic [7:0]       tbl_data;
  logic             sda_i;
  logic             scl_i;
  logic             sda_oe;
  logic             scl_oe;

  modport master (
    output tbl_idx, sda_oe, scl_oe,
    input  tbl_reg, tbl_data, sda_i, scl_i
  );

  modport slave (
    input  tbl_idx, sda_oe, scl_oe,
    output tbl_reg, tbl_data, sda_i, scl_i
  );
endinterface

// File: rtl/iic_cfg_seq.sv
// I2C register-write sequencer. After a start pulse it walks NUM_REGS {reg,data} table entries
// and writes each to DEV_ADDR as S-addr-reg-data-P, with ACK check, NACK retry, SCL stretching
// and sticky done/err reporting.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : 1-cycle pulse, begins a run at entry 0 (ignored while busy)
//   bus        : table index/data and open-drain SDA/SCL (see iic_cfg_seq_if)
//   busy       : run in progress
//   done, err  : sticky end-of-run / retries-exhausted flags, cleared by next start
//   err_idx    : entry that exhausted its retries, valid when err
module iic_cfg_seq #(
  parameter int unsigned HALF_CYC  = 1000,
  parameter int unsigned NUM_REGS  = 21,
  parameter logic [6:0]  DEV_ADDR  = 7'h76,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  iic_cfg_seq_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx
);

  localparam int unsigned TW = $clog2(HALF_CYC);
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StSta1, StSta2, StBlo, StBhi, StStp1, StStp2, StStp3, StGap1, StGap2
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [26:0]      frame_q, frame_d;
  logic [4:0]       slot_q, slot_d;
  logic             bit_q, bit_d;
  logic             nack_q, nack_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [1:0]       sda_sync_q, scl_sync_q, scl_oe_dly_q;
  logic             scl_oe, sda_oe;
  logic             stretch, phase_end, ack_slot;

  // scl_oe is delayed to line up with the synchroniser, so the master's own release latency
  // is not mistaken for a slave holding SCL low.
  assign stretch   = (state_q == StBhi) && !scl_oe_dly_q[1] && !scl_sync_q[1];
  assign phase_end = (timer_q == TW'(HALF_CYC - 1)) && !stretch;
  assign ack_slot  = (slot_q == 5'd8) || (slot_q == 5'd17) || (slot_q == 5'd26);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    frame_d   = frame_q;
    slot_d    = slot_q;
    bit_d     = bit_q;
    nack_d    = nack_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    if (state_q inside {StIdle, StLoad} || phase_end) timer_d = '0;
    else if (!stretch)                                timer_d = timer_q + TW'(1);

    unique case (state_q)
      StIdle: if (start) begin
        state_d = StLoad;
        done_d  = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        retry_d = '0;
      end
      StLoad: begin
        // ACK slots carry a 1 so the driven value (~bit) releases SDA for the slave.
        frame_d = {DEV_ADDR, 1'b0, 1'b1, bus.tbl_reg, 1'b1, bus.tbl_data, 1'b1};
        slot_d  = '0;
        nack_d  = 1'b0;
        state_d = StSta1;
      end
      StSta1: if (phase_end) state_d = StSta2;
      StSta2: if (phase_end) begin
        bit_d   = ~frame_q[26];
        state_d = StBlo;
      end
      StBlo: if (phase_end) state_d = StBhi;
      StBhi: if (phase_end) begin
        if (ack_slot && sda_sync_q[1]) begin
          nack_d  = 1'b1;
          state_d = StStp1;
        end else if (slot_q == 5'd26) begin
          state_d = StStp1;
        end else begin
          slot_d  = slot_q + 5'd1;
          frame_d = {frame_q[25:0], 1'b1};
          bit_d   = ~frame_q[25];
          state_d = StBlo;
        end
      end
      StStp1: if (phase_end) state_d = StStp2;
      StStp2: if (phase_end) state_d = StStp3;
      StStp3: if (phase_end) state_d = StGap1;
      StGap1: if (phase_end) state_d = StGap2;
      StGap2: if (phase_end) begin
        if (!nack_q) begin
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = StLoad;
          end
        end else if (retry_q != RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = StLoad;
        end else begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      StSta2: sda_oe = 1'b1;
      StBlo: begin
        scl_oe = 1'b1;
        sda_oe = bit_q;
      end
      StBhi:  sda_oe = bit_q;
      StStp1: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
      end
      StStp2: sda_oe = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      frame_q      <= '0;
      slot_q       <= '0;
      bit_q        <= 1'b0;
      nack_q       <= 1'b0;
      idx_q        <= '0;
      retry_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
      sda_sync_q   <= 2'b11;
      scl_sync_q   <= 2'b11;
      scl_oe_dly_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      frame_q      <= frame_d;
      slot_q       <= slot_d;
      bit_q        <= bit_d;
      nack_q       <= nack_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
      sda_sync_q   <= {sda_sync_q[0], bus.sda_i};
      scl_sync_q   <= {scl_sync_q[0], bus.scl_i};
      scl_oe_dly_q <= {scl_oe_dly_q[0], scl_oe};
    end
  end

  assign bus.sda_oe  = sda_oe;
  assign bus.scl_oe  = scl_oe;
  assign bus.tbl_idx = idx_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: bus-level slave model (byte decode, ACK/NACK, SCL stretch)
// against hand-computed byte streams and frame timings (frame = 61*H+1 cycles, H = 4).
module tb_iic_cfg_seq;
  localparam int unsigned HALF_CYC  = 4;
  localparam int unsigned NUM_REGS  = 2;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned IDX_W     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;
  logic [IDX_W-1:0] err_idx;
  logic slv_sda_lo = 1'b0;
  logic slv_scl_lo = 1'b0;

  logic [7:0] reg_rom [2] = '{8'h41, 8'h98};
  logic [7:0] dat_rom [2] = '{8'h10, 8'h03};

  iic_cfg_seq_if #(.IDX_W(IDX_W)) bus ();

  assign bus.scl_i    = ~(bus.scl_oe | slv_scl_lo);
  assign bus.sda_i    = ~(bus.sda_oe | slv_sda_lo);
  assign bus.tbl_reg  = reg_rom[bus.tbl_idx];
  assign bus.tbl_data = dat_rom[bus.tbl_idx];

  iic_cfg_seq #(
    .HALF_CYC (HALF_CYC),
    .NUM_REGS (NUM_REGS),
    .DEV_ADDR (7'h76),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model controls, set by the stimulus process
  int  nack_mode   = 0;  // 0 ack all, 1 nack data byte of first frame, 2 nack address always
  bit  stretch_en  = 1'b0;
  int  frames_base = 0;

  // Slave model state, owned by the monitor process
  logic [7:0] got_bytes [$];
  logic [7:0] shreg = 8'h00;
  int  frames = 0;
  int  bitcnt = 0;
  int  bytenum = 0;
  int  stretch_cnt = 0;
  bit  scl_prev = 1'b1;
  bit  sda_prev = 1'b1;
  bit  scl_m, sda_b, nack_now;

  // Edges are decoded from the master's own SCL drive so a stretch is not seen as extra clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slv_sda_lo  = 1'b0;
        slv_scl_lo  = 1'b0;
        stretch_cnt = 0;
        bitcnt      = 0;
        scl_prev    = 1'b1;
        sda_prev    = 1'b1;
      end else begin
        scl_m = ~bus.scl_oe;
        sda_b = ~(bus.sda_oe | slv_sda_lo);
        if (stretch_cnt > 0) begin
          stretch_cnt--;
          if (stretch_cnt == 0) slv_scl_lo = 1'b0;
        end
        if (scl_m && scl_prev && sda_prev && !sda_b) begin
          bitcnt  = 0;
          bytenum = 0;
        end else if (scl_m && scl_prev && !sda_prev && sda_b) begin
          frames++;
        end else if (scl_m && !scl_prev) begin
          if (bitcnt < 8) begin
            shreg = {shreg[6:0], sda_b};
            bitcnt++;
            if (bitcnt == 8) got_bytes.push_back(shreg);
            if (stretch_en && frames == frames_base && bytenum == 2 && bitcnt == 6) begin
              slv_scl_lo  = 1'b1;
              stretch_cnt = 10;
            end
          end else begin
            bitcnt = 0;
            bytenum++;
          end
        end else if (!scl_m && scl_prev) begin
          nack_now = (nack_mode == 2 && bytenum == 0) ||
                     (nack_mode == 1 && frames == frames_base && bytenum == 2);
          slv_sda_lo = (bitcnt == 8) ? !nack_now : 1'b0;
        end
        scl_prev = scl_m;
        sda_prev = ~(bus.sda_oe | slv_sda_lo);
      end
    end
  end

  logic [7:0] exp_bytes [$];

  task automatic run_seq(input string name, input int mode, input bit stretch, input int mid_start,
                         input int exp_cycles, input int exp_frames, input bit exp_err);
    int base;
    int n;
    bit seen;
    nack_mode   = mode;
    stretch_en  = stretch;
    frames_base = frames;
    base        = got_bytes.size();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy_at_start"}, 32'(busy), 32'd1);
    check({name, " done_clr"}, 32'(done), 32'd0);
    check({name, " err_clr"}, 32'(err), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < exp_cycles + 100) begin
      start = (n == mid_start);
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " cycles"}, n, exp_cycles);
    check({name, " busy_end"}, 32'(busy), 32'd0);
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " frames"}, frames - frames_base, exp_frames);
    check({name, " nbytes"}, got_bytes.size() - base, exp_bytes.size());
    for (int i = 0; i < exp_bytes.size(); i++) begin
      if (base + i < got_bytes.size())
        check($sformatf("%s byte%0d", name, i), 32'(got_bytes[base + i]), 32'(exp_bytes[i]));
    end
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst scl_oe", 32'(bus.scl_oe), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst tbl_idx", 32'(bus.tbl_idx), 32'd0);
    check("rst err_idx", 32'(err_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full run, with a start pulse mid-frame that must be ignored
    exp_bytes = {8'hEC, 8'h41, 8'h10, 8'hEC, 8'h98, 8'h03};
    run_seq("plain", 0, 1'b0, 100, 490, 2, 1'b0);

    // Data byte of entry 0 NACKed once: entry 0 repeated, then entry 1
    exp_bytes = {8'hEC, 8'h41, 8'h10, 8'hEC, 8'h41, 8'h10, 8'hEC, 8'h98, 8'h03};
    run_seq("nack_data", 1, 1'b0, -1, 735, 3, 1'b0);

    // 10-cycle stretch in a data-bit high phase
    exp_bytes = {8'hEC, 8'h41, 8'h10, 8'hEC, 8'h98, 8'h03};
    run_seq("stretch", 0, 1'b1, -1, 500, 2, 1'b0);

    // Address always NACKed: 3 short frames (25*H+1 each) then err on entry 0
    exp_bytes = {8'hEC, 8'hEC, 8'hEC};
    run_seq("nack_addr", 2, 1'b0, -1, 303, 3, 1'b1);
    check("nack_addr err_idx", 32'(err_idx), 32'd0);
    check("nack_addr tbl_idx", 32'(bus.tbl_idx), 32'd0);

    // Restart after error clears flags and reruns everything
    exp_bytes = {8'hEC, 8'h41, 8'h10, 8'hEC, 8'h98, 8'h03};
    run_seq("rerun", 0, 1'b0, -1, 490, 2, 1'b0);

    // Reset mid-frame while both lines are pulled low in entry 1
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(bus.scl_oe && bus.sda_oe && bus.tbl_idx == 1'b1) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrst reached", 32'(n < 400), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst sda_oe", 32'(bus.sda_oe), 32'd0);
    check("midrst scl_oe", 32'(bus.scl_oe), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst tbl_idx", 32'(bus.tbl_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq("after_rst", 0, 1'b0, -1, 490, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
